// File: rtl/tiny_proc_pkg.sv
// Shared types for the tiny processor family: FSM states, opcodes, operand selects, control vector.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tiny_proc_pkg;

    // Five-phase instruction cycle plus a terminal halt state
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_SELECT = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Opcode map (upper nibble of the ROM word)
    localparam logic [3:0] OP_MOV_A_I = 4'h0;
    localparam logic [3:0] OP_MOV_B_I = 4'h1;
    localparam logic [3:0] OP_MOV_A_B = 4'h2;
    localparam logic [3:0] OP_MOV_B_A = 4'h3;
    localparam logic [3:0] OP_ADD_A   = 4'h4;
    localparam logic [3:0] OP_ADD_B   = 4'h5;
    localparam logic [3:0] OP_IN_A    = 4'h6;
    localparam logic [3:0] OP_IN_B    = 4'h7;
    localparam logic [3:0] OP_OUT_I   = 4'h8;
    localparam logic [3:0] OP_OUT_B   = 4'h9;
    localparam logic [3:0] OP_JMP     = 4'hA;
    localparam logic [3:0] OP_JNC     = 4'hB;
    localparam logic [3:0] OP_JC      = 4'hC;
    localparam logic [3:0] OP_SUB_A   = 4'hD;
    localparam logic [3:0] OP_HALT    = 4'hE;
    localparam logic [3:0] OP_SUB_B   = 4'hF;

    // ALU left-operand source
    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_GPIO = 2'd2,
        SEL_ZERO = 2'd3
    } sel_t;

    // Decoded control vector, MSB first: wr_a, wr_b, wr_out, jump, sel[1:0], sub
    typedef struct packed {
        logic wr_a;
        logic wr_b;
        logic wr_out;
        logic jump;
        sel_t sel;
        logic sub;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Control vector that writes nothing and adds zero
    localparam ctrl_t CTRL_NONE = '{
        wr_a:   1'b0,
        wr_b:   1'b0,
        wr_out: 1'b0,
        jump:   1'b0,
        sel:    SEL_ZERO,
        sub:    1'b0
    };

endpackage

// File: rtl/tiny_proc_decoder.sv
// Opcode + carry flag to control vector decoder for the tiny processor core.
// Latency: purely combinational.
// Backpressure: none; the caller samples the vector in its DECODE phase.
module tiny_proc_decoder
    import tiny_proc_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic              cf,
    output logic [CTRL_W-1:0] ctrl_vec
);

    ctrl_t ctrl;

    assign ctrl_vec = ctrl;

    // Map each opcode onto write targets, operand source, add/sub and jump decision
    always_comb begin
        ctrl = CTRL_NONE;
        case (opcode)
            OP_MOV_A_I: ctrl.wr_a = 1'b1;
            OP_MOV_B_I: ctrl.wr_b = 1'b1;
            OP_MOV_A_B: begin ctrl.wr_a = 1'b1;   ctrl.sel = SEL_B;    end
            OP_MOV_B_A: begin ctrl.wr_b = 1'b1;   ctrl.sel = SEL_A;    end
            OP_ADD_A:   begin ctrl.wr_a = 1'b1;   ctrl.sel = SEL_A;    end
            OP_ADD_B:   begin ctrl.wr_b = 1'b1;   ctrl.sel = SEL_B;    end
            OP_IN_A:    begin ctrl.wr_a = 1'b1;   ctrl.sel = SEL_GPIO; end
            OP_IN_B:    begin ctrl.wr_b = 1'b1;   ctrl.sel = SEL_GPIO; end
            OP_OUT_I:   ctrl.wr_out = 1'b1;
            OP_OUT_B:   begin ctrl.wr_out = 1'b1; ctrl.sel = SEL_B;    end
            OP_JMP:     ctrl.jump = 1'b1;
            OP_JNC:     ctrl.jump = ~cf;
            OP_JC:      ctrl.jump = cf;
            OP_SUB_A:   begin ctrl.wr_a = 1'b1;   ctrl.sel = SEL_A; ctrl.sub = 1'b1; end
            OP_SUB_B:   begin ctrl.wr_b = 1'b1;   ctrl.sel = SEL_B; ctrl.sub = 1'b1; end
            default:    ctrl = CTRL_NONE;   // HALT: handled by the core FSM
        endcase
    end

endmodule

// File: rtl/nbit_tiny_processor.sv
// Parametrised multicycle tiny processor: external ROM in, GPIO out, A/B registers, carry flag.
// Latency: 5 cycles per instruction (FETCH, DECODE, SELECT, EXEC, WB); HALT is terminal until reset.
// Backpressure: run=0 stalls the core in FETCH; an instruction already past FETCH always completes.
module nbit_tiny_processor
    import tiny_proc_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset_p,
    input  logic              run,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic [DATA_W+3:0] rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] gpio_out,
    output logic              halted,
    output logic              instr_done
);

    state_t              state_q,  state_d;
    logic [ADDR_W-1:0]   pc_q,     pc_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic                cf_q,     cf_d;
    logic [DATA_W-1:0]   out_q,    out_d;
    logic [3:0]          op_q,     op_d;
    logic [DATA_W-1:0]   imm_q,    imm_d;
    ctrl_t               ctrl_q,   ctrl_d;
    logic [DATA_W-1:0]   opnd_q,   opnd_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                carry_q,  carry_d;

    logic [CTRL_W-1:0]   dec_vec;
    ctrl_t               dec_ctrl;
    logic [DATA_W:0]     alu_tmp;

    // Jump decisions use the flag left by the previous instruction
    tiny_proc_decoder u_decoder (
        .opcode   (op_q),
        .cf       (cf_q),
        .ctrl_vec (dec_vec)
    );

    assign dec_ctrl = ctrl_t'(dec_vec);

    // State register and all datapath flops; reset discards any partial instruction
    always_ff @(posedge clock or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cf_q     <= 1'b0;
            out_q    <= '0;
            op_q     <= '0;
            imm_q    <= '0;
            ctrl_q   <= CTRL_NONE;
            opnd_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cf_q     <= cf_d;
            out_q    <= out_d;
            op_q     <= op_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    // Next-state: fixed phase sequence, run gates FETCH, HALT opcode diverts to HALT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = run ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = (op_q == OP_HALT) ? ST_HALT : ST_SELECT;
            ST_SELECT: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;   // unreachable encodings recover here
        endcase
    end

    // Datapath: each phase updates only its own registers, everything else holds
    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        cf_d     = cf_q;
        out_d    = out_q;
        op_d     = op_q;
        imm_d    = imm_q;
        ctrl_d   = ctrl_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        carry_d  = carry_q;
        alu_tmp  = '0;
        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    op_d  = rom_data[DATA_W+3:DATA_W];
                    imm_d = rom_data[DATA_W-1:0];
                end
            end
            ST_DECODE: ctrl_d = dec_ctrl;
            ST_SELECT: begin
                case (ctrl_q.sel)
                    SEL_A:    opnd_d = a_q;
                    SEL_B:    opnd_d = b_q;
                    SEL_GPIO: opnd_d = gpio_in;
                    default:  opnd_d = '0;
                endcase
            end
            ST_EXEC: begin
                // Extra MSB captures carry on add and borrow on subtract
                if (ctrl_q.sub) begin
                    alu_tmp = {1'b0, opnd_q} - {1'b0, imm_q};
                end else begin
                    alu_tmp = {1'b0, opnd_q} + {1'b0, imm_q};
                end
                result_d = alu_tmp[DATA_W-1:0];
                carry_d  = alu_tmp[DATA_W];
            end
            ST_WB: begin
                cf_d = carry_q;
                if (ctrl_q.wr_a)   a_d   = result_q;
                if (ctrl_q.wr_b)   b_d   = result_q;
                if (ctrl_q.wr_out) out_d = result_q;
                pc_d = ctrl_q.jump ? result_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
            end
            default: ;
        endcase
    end

    // Outputs decoded directly from registered state
    always_comb begin
        rom_addr   = pc_q;
        gpio_out   = out_q;
        halted     = (state_q == ST_HALT);
        instr_done = (state_q == ST_WB);
    end

endmodule
